// File: rtl/usb_tx.sv
// usb_tx: USB full-speed packet transmitter producing SYNC, PID, optional payload and EOP
// with NRZI encoding and bit stuffing; one bit period is 8 clk cycles.
module usb_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] tx_packet,
    input  logic [7:0] tx_packet_data,
    input  logic [6:0] buffer_occupancy,
    output logic       get_tx_packet_data,
    output logic       tx_transfer_active,
    output logic       tx_error,
    output logic       dplus_out,
    output logic       dminus_out
);

    // state   | meaning
    // IDLE    | line held at J, sampling tx_packet every cycle
    // SYNC    | shifting out the sync byte 0x80
    // PID     | shifting out the PID byte
    // LOAD    | last cycle of a bit period: pop FIFO head and launch its bit 0
    // DATA    | shifting out a payload byte
    // EOP_SE0 | two bit periods of SE0
    // EOP_J   | one bit period of J, then back to IDLE
    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        PID,
        LOAD,
        DATA,
        EOP_SE0,
        EOP_J
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    state_t     state_q, state_n;
    logic [2:0] timer_q, timer_n;
    logic [2:0] bit_idx_q, bit_idx_n;
    logic [7:0] byte_q, byte_n;
    logic [7:0] pid_q, pid_n;
    logic       data0_q, data0_n;
    logic [2:0] ones_q, ones_n;
    logic       nrzi_q, nrzi_n;
    logic       dp_q, dp_n;
    logic       dm_q, dm_n;
    logic       err_q, err_n;

    logic       drive;
    logic       drive_bit;
    logic       bit_end;
    logic       stuff_due;
    logic       byte_done;
    logic       start_ok;
    logic [7:0] pid_sel;

    always_comb begin
        pid_sel = 8'h00;
        case (tx_packet)
            4'd1:    pid_sel = 8'hC3;
            4'd2:    pid_sel = 8'hD2;
            4'd3:    pid_sel = 8'h5A;
            4'd4:    pid_sel = 8'h1E;
            default: pid_sel = 8'h00;
        endcase
    end

    assign bit_end   = (timer_q == 3'd0);
    assign stuff_due = (ones_q == 3'd6);
    // A byte is finished only once any stuff bit owed after its last bit has gone out.
    assign byte_done = (bit_idx_q == 3'd7) && !stuff_due;
    assign start_ok  = (tx_packet >= 4'd1) && (tx_packet <= 4'd4) &&
                       !((tx_packet == 4'd1) && (buffer_occupancy > 7'd64));

    always_comb begin
        state_n   = state_q;
        timer_n   = bit_end ? 3'd7 : timer_q - 3'd1;
        bit_idx_n = bit_idx_q;
        byte_n    = byte_q;
        pid_n     = pid_q;
        data0_n   = data0_q;
        ones_n    = ones_q;
        nrzi_n    = nrzi_q;
        dp_n      = dp_q;
        dm_n      = dm_q;
        err_n     = 1'b0;
        drive     = 1'b0;
        drive_bit = 1'b0;

        case (state_q)
            IDLE: begin
                timer_n = 3'd0;
                ones_n  = 3'd0;
                nrzi_n  = 1'b1;
                dp_n    = 1'b1;
                dm_n    = 1'b0;
                if (start_ok) begin
                    state_n   = SYNC;
                    timer_n   = 3'd7;
                    byte_n    = SYNC_BYTE;
                    bit_idx_n = 3'd0;
                    pid_n     = pid_sel;
                    data0_n   = (tx_packet == 4'd1);
                    drive     = 1'b1;
                    drive_bit = SYNC_BYTE[0];
                end else if (tx_packet != 4'd0) begin
                    err_n = 1'b1;
                end
            end

            SYNC, PID, DATA: begin
                if (bit_end) begin
                    drive = 1'b1;
                    if (stuff_due) begin
                        drive_bit = 1'b0;
                    end else if (bit_idx_q != 3'd7) begin
                        bit_idx_n = bit_idx_q + 3'd1;
                        drive_bit = byte_q[bit_idx_n];
                    end else if (state_q == SYNC) begin
                        state_n   = PID;
                        byte_n    = pid_q;
                        bit_idx_n = 3'd0;
                        drive_bit = pid_q[0];
                    end else begin
                        state_n   = EOP_SE0;
                        bit_idx_n = 3'd0;
                        drive     = 1'b0;
                        dp_n      = 1'b0;
                        dm_n      = 1'b0;
                    end
                end else if ((timer_q == 3'd1) && byte_done && (buffer_occupancy != 7'd0) &&
                             ((state_q == DATA) || ((state_q == PID) && data0_q))) begin
                    // Enter LOAD one cycle early so the next byte starts on the bit boundary.
                    state_n = LOAD;
                end
            end

            LOAD: begin
                state_n   = DATA;
                byte_n    = tx_packet_data;
                bit_idx_n = 3'd0;
                drive     = 1'b1;
                drive_bit = tx_packet_data[0];
            end

            EOP_SE0: begin
                if (bit_end) begin
                    if (bit_idx_q[0]) begin
                        state_n = EOP_J;
                        nrzi_n  = 1'b1;
                        dp_n    = 1'b1;
                        dm_n    = 1'b0;
                    end else begin
                        bit_idx_n = 3'd1;
                    end
                end
            end

            EOP_J: begin
                if (bit_end) begin
                    state_n = IDLE;
                    timer_n = 3'd0;
                end
            end

            default: state_n = IDLE;
        endcase

        if (drive) begin
            if (drive_bit) begin
                ones_n = ones_q + 3'd1;
            end else begin
                ones_n = 3'd0;
                nrzi_n = !nrzi_q;
            end
            dp_n = nrzi_n;
            dm_n = !nrzi_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= 3'd0;
            bit_idx_q <= 3'd0;
            byte_q    <= 8'h00;
            pid_q     <= 8'h00;
            data0_q   <= 1'b0;
            ones_q    <= 3'd0;
            nrzi_q    <= 1'b1;
            dp_q      <= 1'b1;
            dm_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_n;
            timer_q   <= timer_n;
            bit_idx_q <= bit_idx_n;
            byte_q    <= byte_n;
            pid_q     <= pid_n;
            data0_q   <= data0_n;
            ones_q    <= ones_n;
            nrzi_q    <= nrzi_n;
            dp_q      <= dp_n;
            dm_q      <= dm_n;
            err_q     <= err_n;
        end
    end

    assign get_tx_packet_data = (state_q == LOAD);
    assign tx_transfer_active = (state_q != IDLE);
    assign tx_error           = err_q;
    assign dplus_out          = dp_q;
    assign dminus_out         = dm_q;

endmodule
